// File: rtl/badger_tx_scheduler_if.sv
// Bundles the requester side (req/base_addr/grant/done/err) and the MAC side
// (buf_start_addr/tx_mac_start/tx_mac_done) of the Badger TX scheduler.
//
// Handshake semantics:
//   req[i] is a level held by source i until done[i] or err[i] pulses.
//   grant[i] is high from the grant cycle until the frame completes or aborts.
//   tx_mac_start is a level held until tx_mac_done is seen high (or the
//   watchdog fires). done[i]/err[i] are single-cycle pulses, never both set.
interface badger_tx_scheduler_if #(
  parameter int NREQ = 2,
  parameter int AW   = 10
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] base_addr;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic [NREQ-1:0]    err;
  logic [AW-1:0]      buf_start_addr;
  logic               tx_mac_start;
  logic               tx_mac_done;

  // Requesters plus MAC model drive this side.
  modport master (
    output req, base_addr, tx_mac_done,
    input  grant, done, err, buf_start_addr, tx_mac_start
  );

  // The scheduler sits on this side.
  modport slave (
    input  req, base_addr, tx_mac_done,
    output grant, done, err, buf_start_addr, tx_mac_start
  );
endinterface

// File: rtl/badger_tx_scheduler.sv
// Round-robin arbiter sharing the Badger MAC transmit path among NREQ frame
// sources. One frame in flight, watchdog on tx_mac_done, forced idle gap
// between frames. All outputs come straight from registers.
module badger_tx_scheduler #(
  parameter int NREQ  = 2,
  parameter int AW    = 10,
  parameter int TMO_W = 16,
  parameter int GAP   = 16
) (
  input  logic                 tx_clk,
  input  logic                 tx_rst_n,
  badger_tx_scheduler_if.slave bus,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PW-1:0]    LAST_IDX = PW'(NREQ - 1);
  localparam logic [PW:0]      NREQ_P   = (PW+1)'(NREQ);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP - 1);
  // Abort fires on the cycle the watchdog would step to all-ones, so
  // tx_mac_start is high for exactly 2**TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] WD_LAST  = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   err_q, err_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              start_q, start_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [TMO_W-1:0]  wd_q, wd_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [PW-1:0]     off;
  logic [PW:0]       pick_sum;
  logic [PW-1:0]     pick_idx;
  logic              pick_found;
  logic [NREQ-1:0]   pick_grant;
  logic [AW-1:0]     pick_addr;
  logic [PW-1:0]     rr_next;

  // Pick the first requester at or after the rr pointer, wrapping modulo NREQ.
  always_comb begin
    req_dbl    = {bus.req, bus.req} >> rr_q;
    req_rot    = req_dbl[NREQ-1:0];
    pick_found = |bus.req;
    off        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) off = PW'(k);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, off};
    if (pick_sum >= NREQ_P) pick_sum = pick_sum - NREQ_P;
    pick_idx   = pick_sum[PW-1:0];
    pick_grant = '0;
    pick_addr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        pick_grant[i] = 1'b1;
        pick_addr     = bus.base_addr[i*AW +: AW];
      end
    end
    rr_next = (gidx_q == LAST_IDX) ? '0 : gidx_q + PW'(1);
  end

  // Next-state and registered-output decode for the frame FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    done_d        = '0;
    err_d         = '0;
    addr_d        = addr_q;
    start_d       = start_q;
    frame_count_d = frame_count_q;
    rr_d          = rr_q;
    gidx_d        = gidx_q;
    wd_d          = wd_q;
    gap_d         = gap_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_grant;
          gidx_d  = pick_idx;
          addr_d  = pick_addr;
          state_d = S_START;
        end
      end
      S_START: begin
        start_d = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the timeout cycle still counts as a completion.
        if (bus.tx_mac_done) begin
          start_d       = 1'b0;
          done_d        = grant_q;
          frame_count_d = frame_count_q + 16'd1;
          rr_d          = rr_next;
          grant_d       = '0;
          gap_d         = '0;
          state_d       = S_GAP;
        end else if (wd_q == WD_LAST) begin
          start_d = 1'b0;
          err_d   = grant_q;
          rr_d    = rr_next;
          grant_d = '0;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          wd_d = wd_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        // Also wait for the MAC to drop tx_mac_done so it cannot be mistaken
        // for the next frame's completion.
        if (gap_q == GAP_LAST) begin
          if (!bus.tx_mac_done) state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops tx_mac_start immediately.
  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      err_q         <= '0;
      addr_q        <= '0;
      start_q       <= 1'b0;
      frame_count_q <= '0;
      rr_q          <= '0;
      gidx_q        <= '0;
      wd_q          <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      start_q       <= start_d;
      frame_count_q <= frame_count_d;
      rr_q          <= rr_d;
      gidx_q        <= gidx_d;
      wd_q          <= wd_d;
      gap_q         <= gap_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.buf_start_addr = addr_q;
  assign bus.tx_mac_start   = start_q;
  assign busy               = (state_q != S_IDLE);
  assign frame_count        = frame_count_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_badger_tx_scheduler.sv
// Bench for badger_tx_scheduler: a MAC model answering tx_mac_start, a
// frame-level reference model filling expectation queues, and a monitor
// popping them on every start edge and done/err pulse.
module tb_badger_tx_scheduler;
  localparam int NREQ    = 3;
  localparam int AW      = 10;
  localparam int TMO_W   = 4;
  localparam int GAP     = 4;
  localparam int TMO_MAX = (1 << TMO_W) - 1;

  typedef struct packed {
    logic [2:0]    idx;
    logic [AW-1:0] addr;
    logic [15:0]   gap;
  } start_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic        is_err;
    logic [15:0] cnt;
  } end_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [15:0] frame_count;
  logic [1:0]  state_dbg;

  badger_tx_scheduler_if #(.NREQ(NREQ), .AW(AW)) bus ();

  badger_tx_scheduler #(.NREQ(NREQ), .AW(AW), .TMO_W(TMO_W), .GAP(GAP)) dut (
    .tx_clk      (clk),
    .tx_rst_n    (rst_n),
    .bus         (bus),
    .busy        (busy),
    .frame_count (frame_count),
    .state_dbg   (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int     n_chk  = 0;
  int     n_fail = 0;
  start_t start_q[$];
  end_t   end_q[$];
  int     len_q[$];
  int     hold_q[$];

  int            rr_m;
  logic [15:0]   count_m;
  logic [AW-1:0] base_m[NREQ];
  int            sc_len[8];
  int            sc_hold[8];
  int            stale_len;
  bit            stale_tog;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=event required=no event at %0t", name, $time);
  endtask

  function automatic logic [NREQ-1:0] oh(input logic [2:0] i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: lowest rotational distance from rr_m wins.
  function automatic int arb(input logic [NREQ-1:0] m);
    int r;
    r = -1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (m[(rr_m + k) % NREQ]) r = (rr_m + k) % NREQ;
    end
    return r;
  endfunction

  // ---------------- MAC model ----------------
  // Raises tx_mac_done after the frame's length in start-high cycles, keeps
  // it up for 'hold' extra cycles after start drops; can also emit stale
  // done pulses while idle.
  initial begin
    int  cnt, cur_len, cur_hold, hold_left, stale_left;
    bit  mac_active, tog_seen;
    bus.tx_mac_done = 1'b0;
    mac_active = 0; cnt = 0; cur_len = 0; cur_hold = 0;
    hold_left = 0; stale_left = 0; tog_seen = 0;
    forever begin
      @(negedge clk);
      if (stale_tog != tog_seen) begin
        tog_seen   = stale_tog;
        stale_left = stale_len;
      end
      if (rst_n && bus.tx_mac_start) begin
        if (!mac_active) begin
          mac_active = 1;
          cnt = 0;
          if (len_q.size() != 0) begin
            cur_len  = len_q.pop_front();
            cur_hold = hold_q.pop_front();
          end else begin
            cur_len  = 1000;
            cur_hold = 0;
          end
        end
        cnt++;
        if (cnt == cur_len) bus.tx_mac_done = 1'b1;
      end else begin
        if (mac_active) begin
          mac_active = 0;
          hold_left  = cur_hold;
        end
        if (stale_left > 0) begin
          bus.tx_mac_done = 1'b1;
          stale_left--;
        end else if (bus.tx_mac_done) begin
          if (hold_left == 0) bus.tx_mac_done = 1'b0;
          else hold_left--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic            prev_start;
    logic [NREQ-1:0] prev_grant;
    int              cyc, last_start;
    start_t          s;
    end_t            e;
    prev_start = 1'b0; prev_grant = '0; cyc = 0; last_start = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_start = 1'b0;
        prev_grant = '0;
      end else begin
        if (bus.tx_mac_start && !prev_start) begin
          if (start_q.size() == 0) begin
            fail_now("unexpected_start");
          end else begin
            s = start_q.pop_front();
            chk("grant_at_start", 32'(bus.grant), 32'(oh(s.idx)));
            chk("grant_1cyc_before_start", 32'(prev_grant), 32'(oh(s.idx)));
            chk("buf_start_addr", 32'(bus.buf_start_addr), 32'(s.addr));
            chk("busy_at_start", 32'(busy), 32'd1);
            if (s.gap != 0) chk("start_spacing", cyc - last_start, 32'(s.gap));
          end
          last_start = cyc;
        end
        if (bus.tx_mac_start) chk("grant_onehot_in_frame", 32'($onehot(bus.grant)), 32'd1);
        if ((bus.done | bus.err) != '0) begin
          chk("pulse_onehot", 32'($onehot(bus.done | bus.err)), 32'd1);
          if (end_q.size() == 0) begin
            fail_now("unexpected_done_err");
          end else begin
            e = end_q.pop_front();
            chk("done_pulse", 32'(bus.done), e.is_err ? 32'd0 : 32'(oh(e.idx)));
            chk("err_pulse", 32'(bus.err), e.is_err ? 32'(oh(e.idx)) : 32'd0);
            chk("frame_count_at_end", 32'(frame_count), 32'(e.cnt));
            chk("grant_dropped_at_end", 32'(bus.grant), 32'd0);
          end
        end
        prev_start = bus.tx_mac_start;
        prev_grant = bus.grant;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bases();
    for (int i = 0; i < NREQ; i++) bus.base_addr[i*AW +: AW] = base_m[i];
  endtask

  // Predict n frames from a held request mask with lengths/holds in sc_*.
  task automatic plan(input logic [NREQ-1:0] mask, input int n);
    start_t s;
    end_t   e;
    int     idx, le, pl, ph;
    bit     pd;
    pl = 0; ph = 0; pd = 0;
    for (int k = 0; k < n; k++) begin
      idx = arb(mask);
      le  = (sc_len[k] > TMO_MAX) ? TMO_MAX : sc_len[k];
      s.idx  = 3'(idx);
      s.addr = base_m[idx];
      if (k == 0) s.gap = '0;
      else s.gap = 16'(pl + (pd ? ((ph + 1 > GAP) ? ph + 1 : GAP) : GAP) + 2);
      start_q.push_back(s);
      e.idx    = 3'(idx);
      e.is_err = (sc_len[k] > TMO_MAX);
      if (!e.is_err) count_m = count_m + 16'd1;
      e.cnt = count_m;
      end_q.push_back(e);
      len_q.push_back(sc_len[k]);
      hold_q.push_back(sc_hold[k]);
      rr_m = (idx + 1) % NREQ;
      pl = le; pd = !e.is_err; ph = sc_hold[k];
    end
  endtask

  task automatic settle();
    int c;
    c = 0;
    while ((busy || bus.tx_mac_done) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) fail_now("settle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic run_scen(input logic [NREQ-1:0] mask, input int n, input bit drop_early);
    int c;
    @(negedge clk);
    drive_bases();
    plan(mask, n);
    bus.req = mask;
    if (drop_early) begin
      c = 0;
      while (!bus.tx_mac_start && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) fail_now("start_timeout");
      bus.req = '0;
    end
    c = 0;
    while ((start_q.size() != 0 || end_q.size() != 0) && c < n * 80) begin
      @(negedge clk);
      c++;
    end
    if (c >= n * 80) begin
      fail_now("scenario_timeout");
      start_q.delete(); end_q.delete(); len_q.delete(); hold_q.delete();
    end
    bus.req = '0;
    settle();
    chk("frame_count_after_scenario", 32'(frame_count), 32'(count_m));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NREQ-1:0] mask;
    int              n, c;
    start_t          s;
    rst_n = 1'b0;
    bus.req = '0;
    bus.base_addr = '0;
    rr_m = 0; count_m = '0; stale_len = 0; stale_tog = 0;
    for (int i = 0; i < NREQ; i++) base_m[i] = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_tx_mac_start", 32'(bus.tx_mac_start), 32'd0);
    chk("rst_buf_start_addr", 32'(bus.buf_start_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Timeout: source 0 never completes, source 1 gets the next grant.
    for (int i = 0; i < NREQ; i++) base_m[i] = AW'($urandom);
    sc_len[0] = 20; sc_hold[0] = 0;
    sc_len[1] = 8;  sc_hold[1] = 0;
    run_scen(3'b011, 2, 0);

    // Single frame from source 0 at 0x040.
    base_m[0] = 10'h040;
    sc_len[0] = 10; sc_hold[0] = 0;
    run_scen(3'b001, 1, 0);

    // Fairness: two sources held, four frames alternate.
    for (int k = 0; k < 4; k++) begin sc_len[k] = 12; sc_hold[k] = 0; end
    run_scen(3'b011, 4, 0);

    // Done on the timeout cycle, with the MAC holding done into the gap.
    sc_len[0] = TMO_MAX; sc_hold[0] = 2;
    sc_len[1] = 5;       sc_hold[1] = 6;
    sc_len[2] = 3;       sc_hold[2] = 0;
    run_scen(3'b100, 3, 0);

    // Stale tx_mac_done while idle is ignored.
    stale_len = 2;
    stale_tog = ~stale_tog;
    repeat (6) @(negedge clk);
    chk("stale_done_count", 32'(frame_count), 32'(count_m));
    chk("stale_done_busy", 32'(busy), 32'd0);

    // Randomized scenarios.
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NREQ; i++) base_m[i] = AW'($urandom);
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        sc_len[k]  = $urandom_range(1, 18);
        sc_hold[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      end
      run_scen(mask, n, ($urandom_range(0, 3) == 0) && (n == 1));
    end

    // Counter wrap, with req dropped mid-frame.
    force dut.frame_count_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.frame_count_q;
    count_m = 16'hFFFF;
    @(negedge clk);
    chk("frame_count_preload", 32'(frame_count), 32'h0000FFFF);
    sc_len[0] = 6; sc_hold[0] = 0;
    mask = oh(3'($urandom_range(0, NREQ - 1)));
    run_scen(mask, 1, 1);
    chk("frame_count_wrapped", 32'(frame_count), 32'd0);

    // Reset in the middle of WAIT.
    sc_len[0] = 3; sc_hold[0] = 0;
    run_scen(3'b001, 1, 0);
    @(negedge clk);
    drive_bases();
    s.idx = 3'd1; s.addr = base_m[1]; s.gap = '0;
    start_q.push_back(s);
    len_q.push_back(12);
    hold_q.push_back(0);
    bus.req = 3'b010;
    c = 0;
    while (!bus.tx_mac_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) fail_now("reset_test_start_timeout");
    repeat (5) @(negedge clk);
    chk("count_before_reset", 32'(frame_count), 32'(count_m));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx_mac_start", 32'(bus.tx_mac_start), 32'd0);
    chk("midrst_grant", 32'(bus.grant), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_frame_count", 32'(frame_count), 32'd0);
    chk("midrst_done_err", 32'(bus.done | bus.err), 32'd0);
    rr_m = 0;
    count_m = '0;
    bus.req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_pulse_after_reset", 32'(frame_count), 32'd0);

    // rr pointer restarts at source 0 after reset.
    sc_len[0] = 4; sc_hold[0] = 0;
    run_scen(3'b011, 1, 0);

    chk("start_q_drained", start_q.size(), 32'd0);
    chk("end_q_drained", end_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
